// File: rtl/out_latch_bbm.sv
// -----------------------------------------------------------------------------
// out_latch_bbm
//
// Switch output latch for N_SW switches, each selecting among N_ANT antennas.
// A new selection is taken either from a local load strobe (falling edge of
// I_load) or, in remote mode, from I_sel on every clock. Requests that would
// connect one antenna to two switches are refused. Accepted changes are applied
// break-before-make: every field that changes is driven to zero for
// DEAD_CYCLES clocks before its new value appears, while fields that do not
// change keep their value throughout.
//
// Parameters
//   N_SW        number of switches (one field each)
//   N_ANT       antennas per switch, i.e. field width
//   DEAD_CYCLES blank time in clocks, 1..255
//
// Ports
//   I_clk        system clock, everything on the rising edge
//   I_rst_n      synchronous active-low reset
//   I_sel        requested selection, field s = I_sel[s*N_ANT +: N_ANT]
//   I_load       asynchronous load strobe, falling edge takes effect
//   I_remote     high = remote mode, I_sel is tracked live
//   O_sel        registered relay drive, high = antenna connected
//   O_busy       high while a break/make sequence is running
//   O_collision  registered: some antenna bit is set in two or more fields
//   O_reject     one-cycle pulse when a local load was refused
//
// Configuration macro
//   OUT_LATCH_ONEHOT_EN  when defined, a field with more than one bit set is
//                        also refused (an all-zero field stays legal).
// -----------------------------------------------------------------------------
module out_latch_bbm #(
   parameter int N_SW        = 2,
   parameter int N_ANT       = 6,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                  I_clk,
   input  logic                  I_rst_n,
   input  logic [N_SW*N_ANT-1:0] I_sel,
   input  logic                  I_load,
   input  logic                  I_remote,
   output logic [N_SW*N_ANT-1:0] O_sel,
   output logic                  O_busy,
   output logic                  O_collision,
   output logic                  O_reject
);

   localparam int         W        = N_SW * N_ANT;
   localparam logic [7:0] CNT_LOAD = 8'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE} state_t;

   state_t           state;
   state_t           state_nx;

   logic             load_s1;
   logic             load_s2;
   logic             load_s2d;
   logic             load_req;

   logic [7:0]       cnt;
   logic [W-1:0]     cur;
   logic [W-1:0]     tgt;
   logic [W-1:0]     chg_mask;
   logic             pend_valid;
   logic [W-1:0]     pend_val;

   logic [N_ANT-1:0] col_seen;
   logic [N_ANT-1:0] col_dup;
   logic [N_ANT-1:0] col_field;
   logic             collision;
   logic             invalid;

   logic             req_valid;
   logic             reject;
   logic             eff_valid;
   logic [W-1:0]     eff_val;
   logic [W-1:0]     diff_mask;
   logic             start;

   logic [W-1:0]     sel_nx;
   logic             busy_nx;

   // Walk the fields once: an antenna bit already seen in an earlier field
   // marks a collision. With the one-hot option, a field holding two or more
   // set bits is flagged as invalid (x & (x-1) clears the lowest set bit).
   always_comb begin
      col_seen  = '0;
      col_dup   = '0;
      col_field = '0;
      invalid   = 1'b0;
      for (int s = 0; s < N_SW; s++) begin
         col_field = I_sel[s*N_ANT +: N_ANT];
         col_dup   = col_dup | (col_seen & col_field);
         col_seen  = col_seen | col_field;
`ifdef OUT_LATCH_ONEHOT_EN
         if ((col_field & (col_field - N_ANT'(1))) != '0)
            invalid = 1'b1;
`else
`endif
      end
      collision = |col_dup;
   end

   // Decide whether I_sel is a usable request this cycle. Remote mode offers
   // it every clock and silently drops bad patterns; local mode only looks at
   // it on a load strobe and answers a bad pattern with a reject pulse. The
   // newest request beats whatever is parked in the pending register, and a
   // per-field mask records which fields would change against the current
   // selection.
   always_comb begin
      req_valid = 1'b0;
      reject    = 1'b0;
      if (I_remote) begin
         req_valid = !(collision || invalid);
      end else if (load_req) begin
         if (collision || invalid)
            reject = 1'b1;
         else
            req_valid = 1'b1;
      end
      eff_valid = req_valid | pend_valid;
      eff_val   = req_valid ? I_sel : pend_val;
      diff_mask = '0;
      for (int s = 0; s < N_SW; s++) begin
         if (eff_val[s*N_ANT +: N_ANT] != cur[s*N_ANT +: N_ANT])
            diff_mask[s*N_ANT +: N_ANT] = '1;
      end
      start = (state == ST_IDLE) && eff_valid && (eff_val != cur);
   end

   // State register of the break/make sequencer.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // Sequencer transitions: leave IDLE only for a real change, stay in BREAK
   // until the dead-time counter has run down, then spend one cycle in MAKE.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_BREAK;
         ST_BREAK: if (cnt == 8'd0) state_nx = ST_MAKE;
         ST_MAKE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   // Next values of the relay drive and busy flag. Busy is raised already in
   // the IDLE cycle that starts a sequence so it covers the whole dead time
   // plus the make cycle. During BREAK only the changing fields are blanked.
   always_comb begin
      sel_nx  = cur;
      busy_nx = 1'b0;
      case (state)
         ST_IDLE:  busy_nx = start;
         ST_BREAK: begin
            sel_nx  = cur & ~chg_mask;
            busy_nx = 1'b1;
         end
         ST_MAKE:  sel_nx = tgt;
         default:  sel_nx = cur;
      endcase
   end

   // Datapath registers: load-strobe synchroniser with falling-edge detect,
   // registered outputs, the dead-time counter, the committed selection and
   // the one-deep pending request. Requests arriving while a sequence runs
   // overwrite the pending slot; it is consumed (or dropped if it matches)
   // on the next IDLE cycle. The synchroniser resets high so that leaving
   // reset never looks like a load edge.
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         load_s1     <= 1'b1;
         load_s2     <= 1'b1;
         load_s2d    <= 1'b1;
         load_req    <= 1'b0;
         cnt         <= 8'd0;
         cur         <= '0;
         tgt         <= '0;
         chg_mask    <= '0;
         pend_valid  <= 1'b0;
         pend_val    <= '0;
         O_sel       <= '0;
         O_busy      <= 1'b0;
         O_collision <= 1'b0;
         O_reject    <= 1'b0;
      end else begin
         load_s1     <= I_load;
         load_s2     <= load_s1;
         load_s2d    <= load_s2;
         load_req    <= load_s2d & ~load_s2;
         O_collision <= collision;
         O_reject    <= reject;
         O_sel       <= sel_nx;
         O_busy      <= busy_nx;
         case (state)
            ST_IDLE: begin
               pend_valid <= 1'b0;
               if (start) begin
                  tgt      <= eff_val;
                  chg_mask <= diff_mask;
                  cnt      <= CNT_LOAD;
               end
            end
            ST_BREAK: begin
               if (cnt != 8'd0)
                  cnt <= cnt - 8'd1;
               if (req_valid) begin
                  pend_valid <= 1'b1;
                  pend_val   <= I_sel;
               end
            end
            ST_MAKE: begin
               cur <= tgt;
               if (req_valid) begin
                  pend_valid <= 1'b1;
                  pend_val   <= I_sel;
               end
            end
            default: pend_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_out_latch_bbm.sv
// -----------------------------------------------------------------------------
// tb_out_latch_bbm
//
// Directed bench for out_latch_bbm with default parameters (2 switches,
// 6 antennas, 16 dead cycles). Expected final selections are queued when a
// request is driven and popped when the sequencer finishes; timing, blanking
// and reject behaviour are checked around each step.
// -----------------------------------------------------------------------------
module tb_out_latch_bbm;

   localparam int W = 12;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic         load   = 1'b1;
   logic         remote = 1'b0;
   logic [W-1:0] sel    = '0;
   logic [W-1:0] o_sel;
   logic         o_busy;
   logic         o_collision;
   logic         o_reject;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];

   int           lat;
   int           len;
   int           a_zero;
   int           b_glitch;
   int           rej_cnt;
   int           busy_cnt;

   localparam logic [W-1:0] X1 = 12'b000010_000100;
   localparam logic [W-1:0] X2 = 12'b100000_000001;
   localparam logic [W-1:0] X3 = 12'b001000_010000;

   out_latch_bbm dut (
      .I_clk       (clk),
      .I_rst_n     (rst_n),
      .I_sel       (sel),
      .I_load      (load),
      .I_remote    (remote),
      .O_sel       (o_sel),
      .O_busy      (o_busy),
      .O_collision (o_collision),
      .O_reject    (o_reject)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Safety net: the directed sequence is a few hundred cycles long.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   // Compare one observed value against its expectation and count it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and land on the falling edge for sampling/driving.
   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive a new selection and mode (called on a falling edge).
   task automatic applyStimulus(input logic [W-1:0] s, input logic rem);
      sel    = s;
      remote = rem;
   endtask

   // Raise the load strobe and give the synchroniser time to settle.
   task automatic releaseLoad();
      load = 1'b1;
      repeat (4) nextCycle();
   endtask

   // Count clocks until busy rises, bounded.
   task automatic waitBusy(output int cycles);
      cycles = 0;
      while (o_busy !== 1'b1 && cycles < 40) begin
         nextCycle();
         cycles++;
      end
   endtask

   // Count clocks while busy is high, how many samples show field A blank,
   // and how many samples show field B away from its expected value.
   task automatic measureBusy(output int n, output int az, output int bg,
                              input logic [5:0] b_exp);
      n  = 0;
      az = 0;
      bg = 0;
      while (o_busy === 1'b1 && n < 300) begin
         nextCycle();
         n++;
         if (o_sel[5:0] == 6'b0) az++;
         if (o_sel[11:6] != b_exp) bg++;
      end
   endtask

   // Watch reject and busy over a fixed window.
   task automatic watchWindow(input int n, output int rj, output int bz);
      rj = 0;
      bz = 0;
      for (int i = 0; i < n; i++) begin
         nextCycle();
         if (o_reject === 1'b1) rj++;
         if (o_busy === 1'b1) bz++;
      end
   endtask

   initial begin
      // Reset state
      repeat (3) nextCycle();
      checkOutput("rst_sel", o_sel, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_coll", o_collision, 0);
      checkOutput("rst_rej", o_reject, 0);
      rst_n = 1'b1;
      repeat (2) nextCycle();

      // First local load from an empty latch
      $display("[TB] local load from reset");
      applyStimulus(12'b000010_000001, 1'b0);
      exp_q.push_back(12'b000010_000001);
      load = 1'b0;
      waitBusy(lat);
      checkOutput("t2_latency", lat, 4);
      measureBusy(len, a_zero, b_glitch, 6'b000010);
      checkOutput("t2_busy_len", len, 17);
      checkOutput("t2_sel", o_sel, exp_q.pop_front());
      releaseLoad();

      // Change field A only: B must hold, A blank for exactly 16 clocks
      $display("[TB] break-before-make on field A");
      applyStimulus(12'b000010_000100, 1'b0);
      exp_q.push_back(12'b000010_000100);
      load = 1'b0;
      waitBusy(lat);
      checkOutput("t3_latency", lat, 4);
      measureBusy(len, a_zero, b_glitch, 6'b000010);
      checkOutput("t3_busy_len", len, 17);
      checkOutput("t3_a_blank", a_zero, 16);
      checkOutput("t3_b_glitch", b_glitch, 0);
      checkOutput("t3_sel", o_sel, exp_q.pop_front());
      releaseLoad();

      // Colliding local load is refused
      $display("[TB] local collision");
      applyStimulus(12'b000100_000100, 1'b0);
      exp_q.push_back(12'b000010_000100);
      nextCycle();
      checkOutput("t4_coll", o_collision, 1);
      load = 1'b0;
      watchWindow(8, rej_cnt, busy_cnt);
      checkOutput("t4_rej_pulses", rej_cnt, 1);
      checkOutput("t4_busy", busy_cnt, 0);
      checkOutput("t4_sel", o_sel, exp_q.pop_front());
      releaseLoad();

      // Reset in the middle of BREAK, then a clean restart
      $display("[TB] reset mid-break");
      applyStimulus(12'b010000_001000, 1'b0);
      load = 1'b0;
      waitBusy(lat);
      checkOutput("t1_latency", lat, 4);
      repeat (5) nextCycle();
      load  = 1'b1;
      rst_n = 1'b0;
      nextCycle();
      checkOutput("t1_rst_sel", o_sel, 0);
      checkOutput("t1_rst_busy", o_busy, 0);
      rst_n = 1'b1;
      repeat (3) nextCycle();
      applyStimulus(12'b000010_000001, 1'b0);
      exp_q.push_back(12'b000010_000001);
      load = 1'b0;
      waitBusy(lat);
      checkOutput("t1_re_latency", lat, 4);
      measureBusy(len, a_zero, b_glitch, 6'b000010);
      checkOutput("t1_re_busy_len", len, 17);
      checkOutput("t1_re_sel", o_sel, exp_q.pop_front());
      releaseLoad();

      // Remote tracking with two changes during BREAK
      $display("[TB] remote updates during break");
      applyStimulus(X1, 1'b1);
      exp_q.push_back(X1);
      waitBusy(lat);
      checkOutput("t5_latency", lat, 1);
      repeat (2) nextCycle();
      applyStimulus(X2, 1'b1);
      repeat (3) nextCycle();
      applyStimulus(X3, 1'b1);
      exp_q.push_back(X3);
      measureBusy(len, a_zero, b_glitch, 6'b000010);
      checkOutput("t5_first_sel", o_sel, exp_q.pop_front());
      waitBusy(lat);
      checkOutput("t5_second_latency", lat, 1);
      measureBusy(len, a_zero, b_glitch, 6'b001000);
      checkOutput("t5_second_len", len, 17);
      checkOutput("t5_second_a_blank", a_zero, 16);
      checkOutput("t5_second_sel", o_sel, exp_q.pop_front());
      watchWindow(5, rej_cnt, busy_cnt);
      checkOutput("t5_no_third", busy_cnt, 0);

      // Remote collision is ignored without a reject pulse
      $display("[TB] remote collision");
      applyStimulus(12'b000001_000001, 1'b1);
      watchWindow(6, rej_cnt, busy_cnt);
      checkOutput("rc_rej", rej_cnt, 0);
      checkOutput("rc_busy", busy_cnt, 0);
      checkOutput("rc_coll", o_collision, 1);
      checkOutput("rc_sel", o_sel, X3);

      // Multi-bit field in local mode
      $display("[TB] multi-bit field load");
      applyStimulus(12'b010000_000011, 1'b0);
      load = 1'b0;
`ifdef OUT_LATCH_ONEHOT_EN
      exp_q.push_back(X3);
      watchWindow(8, rej_cnt, busy_cnt);
      checkOutput("t6_rej_pulses", rej_cnt, 1);
      checkOutput("t6_busy", busy_cnt, 0);
      checkOutput("t6_sel", o_sel, exp_q.pop_front());
`else
      exp_q.push_back(12'b010000_000011);
      waitBusy(lat);
      checkOutput("t6_latency", lat, 4);
      measureBusy(len, a_zero, b_glitch, 6'b010000);
      checkOutput("t6_busy_len", len, 17);
      checkOutput("t6_sel", o_sel, exp_q.pop_front());
`endif
      releaseLoad();

      checkOutput("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
